// File: rtl/spy_pkg.sv
// Shared definitions for the spy readout block: widths, FSM encoding, header layout.
`default_nettype none

package spy_pkg;

  localparam int SPY_DATA_W = 24;
  localparam int SPY_ADDR_W = 9;
  localparam int SPY_DEPTH  = 2 ** SPY_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FREEZE = 3'd1,
    ST_SNAP   = 3'd2,
    ST_READ   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } spy_state_e;

  // Header word: wrapped flag in the MSB, word count in the low ADDR_W+1 bits.
  localparam int HDR_WRAP_BIT = SPY_DATA_W - 1;
  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_CNT_W    = SPY_ADDR_W + 1;

endpackage

`default_nettype wire

// File: rtl/spy_skid_buf.sv
// Two-entry valid/ready buffer for returned RAM words; occupancy feeds the read-issue throttle.
`default_nettype none

module spy_skid_buf #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occupancy_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         w_pop;

  // The issuer guarantees space, so pushes are never refused.
  assign w_pop       = (cnt_q != 2'd0) & out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign occupancy_o = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (in_valid_i) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, in_valid_i} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/spy_readout.sv
// Freezes the spy, snapshots its pointer and walks the RAM oldest-to-newest onto a valid/ready stream.
// Optional header word before the data: define SPY_READOUT_HEADER_EN.
`default_nettype none

module spy_readout
  import spy_pkg::*;
#(
  parameter int DATA_W = SPY_DATA_W,
  parameter int ADDR_W = SPY_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] spy_last_pos,
  input  logic              spy_wrap,
  output logic              spy_freeze,
  output logic [ADDR_W-1:0] spy_addr,
  output logic              spy_rd_en,
  input  logic [DATA_W-1:0] spy_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

`ifdef SPY_READOUT_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  spy_state_e        state_q, state_d;
  logic              wrapped_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              hold_q;

  logic [ADDR_W:0]   w_count_snap;
  logic [ADDR_W-1:0] w_base_snap;
  logic [DATA_W-1:0] w_hdr_word;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic [2:0]        w_level;
  logic              w_can_issue;
  logic              w_issue;
  logic              w_hdr_push;
  logic              w_skid_valid;
  logic [DATA_W:0]   w_skid_in;
  logic [DATA_W:0]   w_skid_out;

  assign w_count_snap = wrapped_q ? FULL_CNT : {1'b0, spy_last_pos};
  assign w_base_snap  = wrapped_q ? spy_last_pos : '0;

  always_comb begin
    w_hdr_word              = '0;
    w_hdr_word[DATA_W-1]    = wrapped_q;
    w_hdr_word[ADDR_W:0]    = w_count_snap;
  end

  // Counting the word leaving this cycle keeps 1 word/cycle with a 2-deep buffer
  // while still never issuing a read that would have nowhere to land.
  assign w_pop       = out_valid & out_ready;
  assign w_level     = {1'b0, w_occ} + {2'b0, inflight_q} - {2'b0, w_pop};
  assign w_can_issue = (w_level < 3'd2);

  always_comb begin
    state_d    = state_q;
    w_issue    = 1'b0;
    w_hdr_push = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FREEZE;
      ST_FREEZE: state_d = ST_SNAP;
      ST_SNAP: begin
        w_hdr_push = HDR_EN;
        if (w_count_snap == '0) state_d = HDR_EN ? ST_DRAIN : ST_DONE;
        else                    state_d = ST_READ;
      end
      ST_READ: begin
        w_issue = w_can_issue & ~hold_q;
        if (w_issue && (remain_q == CNT_ONE)) state_d = ST_DRAIN;
      end
      ST_DRAIN:  if (w_pop && out_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wrapped_q       <= 1'b0;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      hold_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= w_issue;
      inflight_last_q <= w_issue && (remain_q == CNT_ONE);
      if (spy_wrap && !spy_freeze) wrapped_q <= 1'b1;
      if (state_q == ST_SNAP) begin
        addr_q   <= w_base_snap;
        remain_q <= w_count_snap;
        // Header takes the first READ cycle, pushing first data one cycle later.
        hold_q   <= HDR_EN;
      end else begin
        if (state_q == ST_READ) hold_q <= 1'b0;
        if (w_issue) begin
          addr_q   <= addr_q + 1'b1;
          remain_q <= remain_q - 1'b1;
        end
      end
    end
  end

  assign w_skid_valid = inflight_q | w_hdr_push;
  assign w_skid_in    = w_hdr_push ? {(w_count_snap == '0), w_hdr_word}
                                   : {inflight_last_q, spy_data};

  spy_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (w_skid_valid),
    .in_data_i   (w_skid_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (w_skid_out),
    .occupancy_o (w_occ)
  );

  assign out_data   = w_skid_out[DATA_W-1:0];
  assign out_last   = w_skid_out[DATA_W];
  assign spy_addr   = addr_q;
  assign spy_rd_en  = w_issue;
  assign busy       = (state_q == ST_FREEZE) || (state_q == ST_SNAP) ||
                      (state_q == ST_READ)   || (state_q == ST_DRAIN);
  assign spy_freeze = busy;
  assign done       = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: doc/spy_readout.md
Name: spy_readout

Overview:
- Reader-side companion of the spy capture buffer. On a host start request it freezes the spy, snapshots the write pointer and wrap status, then walks the spy RAM oldest-to-newest.
- Words leave on a valid/ready stream toward the VME/readout FIFO.
- It accounts for the 1-cycle RAM read latency and releases freeze when the stream completes.

Parameters:
- DATA_W, 24, spy word width
- ADDR_W, 9, spy RAM address width; depth = 2**ADDR_W

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle readout request; ignored while busy
- spy_last_pos  in  ADDR_W  spy write pointer (next address to be written)
- spy_wrap  in  1  one-cycle pulse when the spy pointer wraps past 2**ADDR_W-1
- spy_freeze  out  1  freeze request to the spy writer
- spy_addr  out  ADDR_W  spy RAM read address
- spy_rd_en  out  1  spy RAM read enable
- spy_data  in  DATA_W  spy RAM read data, valid 1 cycle after spy_rd_en
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  marks the final word of the readout
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the readout completes

Behaviour:
- Reset values: spy_freeze=0, spy_rd_en=0, spy_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, wrapped=0, FSM in IDLE.
- wrapped flag:
  - Set by spy_wrap when spy_freeze=0.
  - Sticky until reset. Once wrapped, the RAM stays full.
- FSM states and transitions:
  - IDLE: start moves to FREEZE. busy and spy_freeze go high on the next cycle.
  - FREEZE (1 cycle): lets the in-flight write settle. Next cycle goes to SNAP.
  - SNAP (1 cycle): latch base and count.
    - wrapped=1: base=spy_last_pos, count=2**ADDR_W.
    - wrapped=0: base=0, count=spy_last_pos.
    - count is ADDR_W+1 bits. count==0 goes straight to DONE.
  - READ: issue reads at spy_addr = base+i (mod 2**ADDR_W) for i = 0..count-1. Goes to DRAIN after the last issue.
  - DRAIN: wait until all issued words have been accepted (out_valid & out_ready on the out_last word).
  - DONE (1 cycle): done=1, spy_freeze=0, busy=0. Return to IDLE.
- Flow control:
  - A read is issued only if (skid occupancy + reads in flight) < 2, so no data is ever lost.
  - With out_ready held high, throughput is 1 word/cycle.
  - First out_valid appears 5 cycles after the start cycle (start at T0, freeze T1, snap T2, first rd_en T3, data T4, out_valid T5).
- Stream rules:
  - out_data/out_valid/out_last hold stable while out_valid & ~out_ready.
  - out_last is high only with the final word.
- Address wrap: spy_addr increments modulo 2**ADDR_W. No special case at 2**ADDR_W-1 → 0.
- spy_wrap arriving while frozen: ignored. The writer does not advance while frozen.
- start during busy: ignored. No queuing.
- reset mid-readout: immediate return to IDLE with all outputs at reset values. spy_freeze drops. wrapped clears.

Optional Feature:
- Macro SPY_READOUT_HEADER_EN.
- Defined: one header word precedes the data.
  - Header layout: out_data[DATA_W-1]=wrapped, out_data[ADDR_W:0]=count, other bits 0.
  - The header is presented in the cycle after SNAP.
  - For count==0 the header alone is sent with out_last=1, then DONE.
  - First data word latency grows by 1 cycle.
- Not defined: no header. count==0 emits no words and produces done only.

Decomposition:
- Shared package spy_pkg:
  - SPY_DATA_W=24, SPY_ADDR_W=9, SPY_DEPTH.
  - FSM state enum (IDLE, FREEZE, SNAP, READ, DRAIN, DONE).
  - Header bit-position constants.
- One sub-module, spy_skid_buf: 2-entry valid/ready skid buffer holding returned RAM data plus its last tag. It provides an occupancy output to the issue logic.

Test Plan:
- No wrap, spy_last_pos=5, RAM[0..4]=0xA00000..0xA00004, out_ready=1, start → 5 words 0xA00000..0xA00004 on consecutive cycles. out_last on the 5th word. done 1 cycle after, then spy_freeze=0.
- Wrapped (one spy_wrap pulse earlier), spy_last_pos=0x1FE, RAM[i]=i → 512 words in order 0x1FE, 0x1FF, 0x000 … 0x1FD. out_last on 0x1FD.
- Backpressure: same as test 1 with out_ready toggling 1,0,0,1 repeated → same 5 words, no loss or duplicate. out_data stable while stalled.
- Empty: spy_last_pos=0, not wrapped, start → no out_valid, done pulse 3 cycles after start. With SPY_READOUT_HEADER_EN: one word 0x000000 with out_last.
- Reset asserted at the 3rd data word of test 2 → next cycle out_valid=0, spy_freeze=0, busy=0. A new start after reset sees wrapped=0.
- start re-pulsed while busy, and spy_wrap pulsed while frozen → no effect on the word sequence or on the wrapped flag.
